// File: rtl/uflash_arbiter.sv
// Two-requester round-robin front end for a single uflash controller.
// Forwards whole transactions and stalls erases until the post-program gap has elapsed.
module uflash_arbiter #(
    parameter int CLK_FREQ = 5400000,
    parameter int GAP_MS   = 10
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_sel,
    input  logic [3:0]  a_wstrb,
    input  logic [14:0] a_addr,
    input  logic [31:0] a_data_i,
    output logic        a_ready,
    output logic [31:0] a_data_o,

    input  logic        b_sel,
    input  logic [3:0]  b_wstrb,
    input  logic [14:0] b_addr,
    input  logic [31:0] b_data_i,
    output logic        b_ready,
    output logic [31:0] b_data_o,

    output logic        f_sel,
    output logic [3:0]  f_wstrb,
    output logic [14:0] f_addr,
    output logic [31:0] f_data_i,
    input  logic        f_ready,
    input  logic [31:0] f_data_o,

    output logic        gap_active
);

    localparam int          GAP_CLKS_I = $rtoi(real'(CLK_FREQ) * real'(GAP_MS) * 1.0e-3) + 1;
    localparam logic [23:0] GAP_CLKS   = 24'(GAP_CLKS_I);

    localparam logic [3:0] OP_PROGRAM = 4'b1111;
    localparam logic [3:0] OP_ERASE   = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        gnt_reg, gnt_next;     // 0 = A, 1 = B
    logic        rr_reg, rr_next;       // requester that wins a tie
    logic        f_sel_reg, f_sel_next;
    logic [3:0]  f_wstrb_reg, f_wstrb_next;
    logic [14:0] f_addr_reg, f_addr_next;
    logic [31:0] f_data_reg, f_data_next;
    logic [23:0] timer_reg, timer_next;
    logic        gap_active_reg;
    logic        win;

    // Requester ports gathered into indexable form so the grant can select by gnt
    logic [1:0]  req_sel;
    logic [3:0]  req_wstrb [2];
    logic [14:0] req_addr  [2];
    logic [31:0] req_data  [2];

    logic        ready_reg  [2];
    logic        ready_next [2];
    logic [31:0] data_o_reg  [2];
    logic [31:0] data_o_next [2];

    assign req_sel      = {b_sel, a_sel};
    assign req_wstrb[0] = a_wstrb;
    assign req_wstrb[1] = b_wstrb;
    assign req_addr[0]  = a_addr;
    assign req_addr[1]  = b_addr;
    assign req_data[0]  = a_data_i;
    assign req_data[1]  = b_data_i;

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        rr_next      = rr_reg;
        f_sel_next   = f_sel_reg;
        f_wstrb_next = f_wstrb_reg;
        f_addr_next  = f_addr_reg;
        f_data_next  = f_data_reg;
        win          = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ready_next[i]  = 1'b0;
            data_o_next[i] = data_o_reg[i];
        end

        // Gap timer counts down to zero; a completed program reloads it below
        timer_next = (timer_reg != 24'd0) ? timer_reg - 24'd1 : 24'd0;

        case (state_reg)
            IDLE: begin
                if (req_sel != 2'b00) begin
                    win          = req_sel[1] && (!req_sel[0] || rr_reg);
                    gnt_next     = win;
                    rr_next      = ~win;
                    f_wstrb_next = req_wstrb[win];
                    f_addr_next  = req_addr[win];
                    f_data_next  = req_data[win];
                    if (req_wstrb[win] == OP_ERASE && timer_reg != 24'd0) begin
                        state_next = HOLD;
                    end else begin
                        f_sel_next = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end

            HOLD: begin
                if (timer_reg == 24'd0) begin
                    f_sel_next = 1'b1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                if (f_ready) begin
                    // Drop sel on the same edge so uflash returns to idle with sel low
                    f_sel_next           = 1'b0;
                    data_o_next[gnt_reg] = f_data_o;
                    ready_next[gnt_reg]  = 1'b1;
                    state_next           = RESP;
                    if (f_wstrb_reg == OP_PROGRAM) begin
                        timer_next = GAP_CLKS;
                    end
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                f_sel_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            gnt_reg        <= 1'b0;
            rr_reg         <= 1'b0;
            f_sel_reg      <= 1'b0;
            f_wstrb_reg    <= 4'd0;
            f_addr_reg     <= 15'd0;
            f_data_reg     <= 32'd0;
            timer_reg      <= 24'd0;
            gap_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            rr_reg         <= rr_next;
            f_sel_reg      <= f_sel_next;
            f_wstrb_reg    <= f_wstrb_next;
            f_addr_reg     <= f_addr_next;
            f_data_reg     <= f_data_next;
            timer_reg      <= timer_next;
            gap_active_reg <= (timer_next != 24'd0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ready_reg[gi]  <= 1'b0;
                    data_o_reg[gi] <= 32'd0;
                end else begin
                    ready_reg[gi]  <= ready_next[gi];
                    data_o_reg[gi] <= data_o_next[gi];
                end
            end
        end
    endgenerate

    assign a_ready    = ready_reg[0];
    assign a_data_o   = data_o_reg[0];
    assign b_ready    = ready_reg[1];
    assign b_data_o   = data_o_reg[1];
    assign f_sel      = f_sel_reg;
    assign f_wstrb    = f_wstrb_reg;
    assign f_addr     = f_addr_reg;
    assign f_data_i   = f_data_reg;
    assign gap_active = gap_active_reg;

endmodule
